// File: rtl/multdiv_sequential.sv
// Signed 32-bit multiply/divide, one add/sub-shift step per clock on operand magnitudes.
// Latency: result strobe 34 cycles after the start edge; a new start from any state aborts and restarts.
module multdiv_sequential #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    typedef enum logic [2:0] {
        IDLE,
        RUN_MULT,
        RUN_DIV,
        FIX,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg;
    logic               is_mult;

    logic               start;
    logic               iter_done;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_hi;
    logic [WIDTH:0]     div_r;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic               mul_exc;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_exc;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign iter_done = (counter == CNT_W'(WIDTH));
    assign abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply: upper half of prod accumulates, lower half holds the multiplier bits still to consume.
    assign mul_hi = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign div_r   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign div_ge  = (div_r >= {1'b0, mag_b});
    assign div_sub = div_r[WIDTH-1:0] - mag_b;
    assign div_rem = div_ge ? div_sub : div_r[WIDTH-1:0];

    assign prod_s  = neg ? -prod : prod;
    assign quo_s   = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign mul_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        fix_result = '0;
        fix_exc    = 1'b0;
        if (is_mult) begin
            fix_result = prod_s[WIDTH-1:0];
            fix_exc    = mul_exc;
        end else if (mag_b == '0) begin
            fix_exc    = 1'b1;
        end else begin
            fix_result = quo_s;
            // Only a positive quotient of 2^WIDTH-1 magnitude (MIN / -1) cannot be represented.
            fix_exc    = !neg && prod[WIDTH-1];
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ctrl_MULT ? RUN_MULT : RUN_DIV;
        end else begin
            case (state)
                RUN_MULT, RUN_DIV: if (iter_done) state_nxt = FIX;
                FIX:               state_nxt = DONE;
                DONE:              state_nxt = IDLE;
                default:           state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter        <= '0;
            prod           <= '0;
            mag_a          <= '0;
            mag_b          <= '0;
            neg            <= 1'b0;
            is_mult        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            counter <= '0;
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            is_mult <= ctrl_MULT;
            prod    <= ctrl_MULT ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
        end else begin
            case (state)
                RUN_MULT: if (!iter_done) begin
                    prod    <= {mul_hi, prod[WIDTH-1:1]};
                    counter <= counter + 1'b1;
                end
                RUN_DIV: if (!iter_done) begin
                    prod    <= {div_rem, prod[WIDTH-2:0], div_ge};
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    data_result    <= fix_result;
                    data_exception <= fix_exc;
                end
                default: ;
            endcase
        end
    end

    assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_multdiv_sequential.sv
// Directed-vector bench for multdiv_sequential: latency, signed results, exceptions, restart and reset abort.
module tb_multdiv_sequential;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_cmp;
    int n_err;

    multdiv_sequential #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse a start for one edge, then scramble the operands (they must be ignored afterwards).
    task automatic start_op(input logic mult, input logic div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mult;
        ctrl_DIV      = div;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEADBEEF;
        data_operandB = 32'h5A5A5A5A;
    endtask

    // Cycles from the start edge to the first strobe seen; -1 if none within the bound.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (data_result !== 32'h0) begin
            n_err++; $display("FAIL reset_result: got %h want %h", data_result, 32'h0);
        end
        n_cmp++;
        if (data_exception !== 1'b0) begin
            n_err++; $display("FAIL reset_exc: got %b want 0", data_exception);
        end
        n_cmp++;
        if (data_resultRDY !== 1'b0) begin
            n_err++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mult;
        logic [31:0] va[3] = '{32'h00000007, 32'h00010000, 32'h80000000};
        logic [31:0] vb[3] = '{32'hFFFFFFFD, 32'h00010000, 32'h00000001};
        logic [31:0] vr[3] = '{32'hFFFFFFEB, 32'h00000000, 32'h80000000};
        logic        ve[3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(1'b1, 1'b0, va[i], vb[i]);
            wait_rdy(lat);
            n_cmp++;
            if (lat !== 34) begin
                n_err++; $display("FAIL mult%0d_latency: got %0d want 34", i, lat);
            end
            n_cmp++;
            if (data_result !== vr[i]) begin
                n_err++; $display("FAIL mult%0d_result: got %h want %h", i, data_result, vr[i]);
            end
            n_cmp++;
            if (data_exception !== ve[i]) begin
                n_err++; $display("FAIL mult%0d_exc: got %b want %b", i, data_exception, ve[i]);
            end
            repeat (3) @(negedge clock);
            n_cmp++;
            if (data_resultRDY !== 1'b0 || data_result !== vr[i]) begin
                n_err++; $display("FAIL mult%0d_hold: rdy %b result %h want rdy 0 result %h",
                                  i, data_resultRDY, data_result, vr[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] va[4] = '{32'hFFFFFFEC, 32'h00000005, 32'h80000000, 32'h00000000};
        logic [31:0] vb[4] = '{32'h00000003, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9};
        logic [31:0] vr[4] = '{32'hFFFFFFFA, 32'h00000000, 32'h80000000, 32'h00000000};
        logic        ve[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(1'b0, 1'b1, va[i], vb[i]);
            wait_rdy(lat);
            n_cmp++;
            if (lat !== 34) begin
                n_err++; $display("FAIL div%0d_latency: got %0d want 34", i, lat);
            end
            n_cmp++;
            if (data_result !== vr[i]) begin
                n_err++; $display("FAIL div%0d_result: got %h want %h", i, data_result, vr[i]);
            end
            n_cmp++;
            if (data_exception !== ve[i]) begin
                n_err++; $display("FAIL div%0d_exc: got %b want %b", i, data_exception, ve[i]);
            end
            @(negedge clock);
            n_cmp++;
            if (data_resultRDY !== 1'b0) begin
                n_err++; $display("FAIL div%0d_rdy_one_cycle: got %b want 0", i, data_resultRDY);
            end
        end
    endtask

    task automatic test_restart;
        logic       both[2] = '{1'b0, 1'b1};
        logic [31:0] vr[2]  = '{32'd14, 32'd700};
        int lat;
        int extra;
        for (int i = 0; i < 2; i++) begin
            start_op(1'b1, 1'b0, 32'd3, 32'd4);
            repeat (9) @(posedge clock);
            start_op(both[i], 1'b1, 32'd100, 32'd7);
            wait_rdy(lat);
            n_cmp++;
            if (lat !== 34) begin
                n_err++; $display("FAIL restart%0d_latency: got %0d want 34", i, lat);
            end
            n_cmp++;
            if (data_result !== vr[i] || data_exception !== 1'b0) begin
                n_err++; $display("FAIL restart%0d_result: got %h exc %b want %h exc 0",
                                  i, data_result, data_exception, vr[i]);
            end
            count_strobes(40, extra);
            n_cmp++;
            if (extra !== 0) begin
                n_err++; $display("FAIL restart%0d_extra_strobes: got %0d want 0", i, extra);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int extra;
        start_op(1'b0, 1'b1, 32'd1000, 32'd10);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs: result %h exc %b rdy %b want 0 0 0",
                              data_result, data_exception, data_resultRDY);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        count_strobes(40, extra);
        n_cmp++;
        if (extra !== 0) begin
            n_err++; $display("FAIL midreset_strobes: got %0d want 0", extra);
        end
        start_op(1'b1, 1'b0, 32'd6, 32'd7);
        wait_rdy(lat);
        n_cmp++;
        if (lat !== 34) begin
            n_err++; $display("FAIL midreset_latency: got %0d want 34", lat);
        end
        n_cmp++;
        if (data_result !== 32'd42 || data_exception !== 1'b0) begin
            n_err++; $display("FAIL midreset_result: got %h exc %b want %h exc 0",
                              data_result, data_exception, 32'd42);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_mult();
        test_div();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
